pump_drain_sequencer: RTL and testbench

Sequencing controller for the flood-monitor pump datapath. It watches the sensor water level, raises an alarm at the high threshold, and on operator command runs a timed drain at the selected pump speed until the low threshold is reached. It sits between the level sensor/buttons and the seven-segment display logic: it supplies the displayed level, the pump speed digit and the pump status flags.

---
 rtl/pump_drain_sequencer_if.sv | 25 ++
 rtl/pump_drain_sequencer.sv | 123 ++++++++++++
 tb/tb_pump_drain_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pump_drain_sequencer_if.sv
// Sensor/button inputs and display/status outputs of the pump drain sequencer.
// The master side drives the sensor and buttons; the slave side is the sequencer.
interface pump_drain_sequencer_if;
  logic [3:0] water_level_int;
  logic       water_level_frac;
  logic       btn0;
  logic       btn7;
  logic [3:0] level_int;
  logic       level_frac;
  logic [1:0] pump_speed;
  logic       pump_on;
  logic       alarm;
  logic       done;
  logic [1:0] state;

  modport master (
    output water_level_int, water_level_frac, btn0, btn7,
    input  level_int, level_frac, pump_speed, pump_on, alarm, done, state
  );

  modport slave (
    input  water_level_int, water_level_frac, btn0, btn7,
    output level_int, level_frac, pump_speed, pump_on, alarm, done, state
  );
endinterface

// File: rtl/pump_drain_sequencer.sv
// Flood-monitor pump sequencer: tracks the sensor level, raises an alarm at the
// high threshold and, on operator command, drains in timed steps down to the
// low threshold. Levels are held internally in half-units.
module pump_drain_sequencer #(
  parameter int TICK_CYCLES = 50_000_000,
  parameter int HIGH_TH     = 12,
  parameter int LOW_TH      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  pump_drain_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALARM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          CW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);
  localparam logic [3:0]  HIGH_LVL  = 4'(HIGH_TH);
  localparam logic [5:0]  FLOOR     = 6'(2 * LOW_TH);

  state_t        st;
  logic [4:0]    lvl;
  logic [1:0]    speed;
  logic [CW-1:0] cnt;
  logic          btn0_d;
  logic          btn7_d;

  logic [4:0] sensor;
  logic       btn0_rise;
  logic       btn7_rise;
  logic       tick;
  logic       high;
  logic [5:0] stepped;

  assign sensor    = {bus.water_level_int, bus.water_level_frac};
  assign btn0_rise = bus.btn0 & ~btn0_d;
  assign btn7_rise = bus.btn7 & ~btn7_d;
  assign tick      = (st == DRAIN) && (cnt == TICK_LAST);
  assign high      = (bus.water_level_int >= HIGH_LVL);
  // Six bits wide so a step below zero shows up as a set sign bit.
  assign stepped   = {1'b0, lvl} - {3'b000, speed, 1'b0};

  // Delayed copies of the buttons so only rising edges act.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn0_d <= 1'b0;
      btn7_d <= 1'b0;
    end else begin
      btn0_d <= bus.btn0;
      btn7_d <= bus.btn7;
    end
  end

  // Pump speed cycles 1 -> 2 -> 3 -> 1 on each btn7 rise, in any state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      speed <= 2'd1;
    end else if (btn7_rise) begin
      speed <= (speed == 2'd3) ? 2'd1 : speed + 2'd1;
    end
  end

  // Main sequencer: state, level register and drain step counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st  <= IDLE;
      lvl <= 5'd0;
      cnt <= '0;
    end else begin
      case (st)
        IDLE: begin
          lvl <= sensor;
          cnt <= '0;
          if (high) st <= ALARM;
        end
        ALARM: begin
          lvl <= sensor;
          cnt <= '0;
          if (btn0_rise)  st <= DRAIN;
          else if (!high) st <= IDLE;
        end
        DRAIN: begin
          if (btn0_rise) begin
            st  <= IDLE;
            cnt <= '0;
          end else if (tick) begin
            cnt <= '0;
            if (!stepped[5] && (stepped > FLOOR)) begin
              lvl <= stepped[4:0];
            end else begin
              lvl <= FLOOR[4:0];
              st  <= DONE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          cnt <= '0;
          if (btn0_rise) st <= IDLE;
        end
        default: begin
          st  <= IDLE;
          cnt <= '0;
        end
      endcase
    end
  end

  assign bus.level_int  = lvl[4:1];
  assign bus.level_frac = lvl[0];
  assign bus.pump_speed = speed;
  assign bus.pump_on    = (st == DRAIN);
  assign bus.alarm      = (st == ALARM);
  assign bus.done       = (st == DONE);
  assign bus.state      = st;

endmodule

// File: tb/tb_pump_drain_sequencer.sv
// Directed self-checking bench for pump_drain_sequencer with a 4-cycle tick.
module tb_pump_drain_sequencer;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  pump_drain_sequencer_if bus ();

  pump_drain_sequencer #(
    .TICK_CYCLES (4),
    .HIGH_TH     (12),
    .LOW_TH      (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // 100 MHz free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not reach end, got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Level compared in half-units, i.e. {level_int, level_frac}.
  task automatic checkLevel(input string tag, input int half);
    checkOutput(tag, int'({bus.level_int, bus.level_frac}), half);
  endtask

  task automatic checkStatus(input string tag, input int st, input int on, input int al, input int dn);
    checkOutput({tag, ".state"}, int'(bus.state), st);
    checkOutput({tag, ".pump_on"}, int'(bus.pump_on), on);
    checkOutput({tag, ".alarm"}, int'(bus.alarm), al);
    checkOutput({tag, ".done"}, int'(bus.done), dn);
  endtask

  task automatic applyStimulus(input int half, input bit b0, input bit b7);
    bus.water_level_int  = 4'(half >> 1);
    bus.water_level_frac = half[0];
    bus.btn0             = b0;
    bus.btn7             = b7;
  endtask

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    applyStimulus(0, 1'b0, 1'b0);
    cycle(2);

    // Reset values
    checkStatus("reset", 0, 0, 0, 0);
    checkLevel("reset.level", 0);
    checkOutput("reset.speed", int'(bus.pump_speed), 1);

    // Level tracking in IDLE
    rst = 1'b1;
    applyStimulus(11, 1'b0, 1'b0);
    cycle(1);
    checkLevel("track.5_5", 11);
    checkStatus("track", 0, 0, 0, 0);

    // Alarm entry and exit
    applyStimulus(23, 1'b0, 1'b0);
    cycle(1);
    checkOutput("alarm.below.state", int'(bus.state), 0);
    applyStimulus(24, 1'b0, 1'b0);
    cycle(1);
    checkStatus("alarm.enter", 1, 0, 1, 0);
    checkLevel("alarm.level", 24);
    applyStimulus(22, 1'b0, 1'b0);
    cycle(1);
    checkStatus("alarm.exit", 0, 0, 0, 0);

    // Full drain at speed 1 from 14.5
    applyStimulus(29, 1'b0, 1'b0);
    cycle(1);
    checkOutput("drain1.alarm", int'(bus.state), 1);
    applyStimulus(29, 1'b1, 1'b0);
    cycle(1);
    checkStatus("drain1.enter", 2, 1, 0, 0);
    checkLevel("drain1.capture", 29);
    applyStimulus(18, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cycle(3);
      checkLevel("drain1.hold", 29 - 2 * (k - 1));
      cycle(1);
      checkLevel("drain1.step", 29 - 2 * k);
    end
    cycle(4);
    checkLevel("drain1.clamp", 12);
    checkStatus("drain1.done", 3, 0, 0, 1);
    cycle(2);
    checkLevel("drain1.done_hold", 12);
    applyStimulus(18, 1'b1, 1'b0);
    cycle(1);
    checkOutput("drain1.ack.state", int'(bus.state), 0);
    applyStimulus(18, 1'b0, 1'b0);
    cycle(1);
    checkLevel("drain1.retrack", 18);

    // Speed change during drain from 15.0
    applyStimulus(30, 1'b0, 1'b0);
    cycle(1);
    applyStimulus(30, 1'b1, 1'b0);
    cycle(1);
    applyStimulus(30, 1'b0, 1'b0);
    cycle(4);
    checkLevel("speed.tick1", 28);
    applyStimulus(30, 1'b0, 1'b1);
    cycle(1);
    checkOutput("speed.to2", int'(bus.pump_speed), 2);
    applyStimulus(30, 1'b0, 1'b0);
    cycle(1);
    applyStimulus(30, 1'b0, 1'b1);
    cycle(1);
    checkOutput("speed.to3", int'(bus.pump_speed), 3);
    applyStimulus(30, 1'b0, 1'b0);
    cycle(1);
    checkLevel("speed.tick2", 22);
    cycle(4);
    checkLevel("speed.tick3", 16);
    cycle(4);
    checkLevel("speed.clamp", 12);
    checkStatus("speed.done", 3, 0, 0, 1);
    applyStimulus(30, 1'b1, 1'b0);
    cycle(1);
    applyStimulus(30, 1'b0, 1'b0);
    checkOutput("speed.ack.state", int'(bus.state), 0);

    // btn7 rise on a tick uses old speed; btn0 rise on a tick aborts
    cycle(1);
    applyStimulus(30, 1'b1, 1'b0);
    cycle(1);
    checkOutput("simul.enter", int'(bus.state), 2);
    applyStimulus(30, 1'b0, 1'b0);
    cycle(3);
    applyStimulus(30, 1'b0, 1'b1);
    cycle(1);
    checkLevel("simul.old_speed", 24);
    checkOutput("simul.speed_wrap", int'(bus.pump_speed), 1);
    applyStimulus(30, 1'b0, 1'b0);
    cycle(4);
    checkLevel("simul.new_speed", 22);
    cycle(3);
    applyStimulus(30, 1'b1, 1'b0);
    cycle(1);
    checkStatus("simul.abort", 0, 0, 0, 0);
    checkLevel("simul.abort_level", 22);

    // Step landing exactly on the floor ends the drain
    applyStimulus(24, 1'b0, 1'b0);
    cycle(1);
    checkOutput("floor.alarm", int'(bus.state), 1);
    applyStimulus(24, 1'b1, 1'b0);
    cycle(1);
    applyStimulus(24, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      cycle(4);
      checkLevel("floor.step", 24 - 2 * k);
    end
    checkOutput("floor.still_drain", int'(bus.state), 2);
    cycle(4);
    checkLevel("floor.level", 12);
    checkOutput("floor.done", int'(bus.state), 3);
    applyStimulus(24, 1'b1, 1'b0);
    cycle(1);
    applyStimulus(26, 1'b0, 1'b0);

    // Button hold: btn0 held in ALARM, then btn7 held
    cycle(1);
    checkOutput("hold.alarm", int'(bus.state), 1);
    applyStimulus(26, 1'b1, 1'b0);
    cycle(1);
    checkOutput("hold.enter", int'(bus.state), 2);
    cycle(19);
    checkOutput("hold.no_abort", int'(bus.state), 2);
    checkLevel("hold.level", 18);
    applyStimulus(26, 1'b0, 1'b0);
    cycle(1);
    applyStimulus(26, 1'b1, 1'b0);
    cycle(1);
    checkOutput("hold.abort", int'(bus.state), 0);
    applyStimulus(26, 1'b0, 1'b1);
    cycle(10);
    checkOutput("hold.btn7", int'(bus.pump_speed), 2);
    applyStimulus(26, 1'b0, 1'b0);
    cycle(1);
    checkOutput("hold.btn7_release", int'(bus.pump_speed), 2);

    // Reset asserted mid-drain
    applyStimulus(28, 1'b0, 1'b0);
    cycle(1);
    applyStimulus(28, 1'b1, 1'b0);
    cycle(1);
    checkOutput("rstmid.drain", int'(bus.state), 2);
    applyStimulus(28, 1'b0, 1'b0);
    cycle(2);
    rst = 1'b0;
    #1;
    checkStatus("rstmid.async", 0, 0, 0, 0);
    checkLevel("rstmid.level", 0);
    checkOutput("rstmid.speed", int'(bus.pump_speed), 1);
    cycle(1);
    rst = 1'b1;
    applyStimulus(15, 1'b0, 1'b0);
    cycle(1);
    checkOutput("rstmid.idle", int'(bus.state), 0);
    checkLevel("rstmid.track", 15);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
